// File: rtl/bram_resp_mem_if.sv
// bram_resp_mem_if
//   BRAM port bundle between a PE controller (master) and the memory
//   responder (slave), plus the controller's completion flag.
//
//   BRAM_ADDR    master -> slave  byte address
//   BRAM_WRDATA  master -> slave  write data
//   BRAM_WE      master -> slave  byte-lane write enables
//   BRAM_EN      master -> slave  port enable
//   BRAM_RST     master -> slave  synchronous clear of read data
//   BRAM_RDDATA  slave  -> master registered read data
//   done         master -> slave  controller completion flag
interface bram_resp_mem_if #(
    parameter int BRAM_ADDR_WIDTH = 15
);
    logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR;
    logic [31:0]                BRAM_WRDATA;
    logic [3:0]                 BRAM_WE;
    logic                       BRAM_EN;
    logic                       BRAM_RST;
    logic [31:0]                BRAM_RDDATA;
    logic                       done;

    modport master (
        output BRAM_ADDR,
        output BRAM_WRDATA,
        output BRAM_WE,
        output BRAM_EN,
        output BRAM_RST,
        output done,
        input  BRAM_RDDATA
    );

    modport slave (
        input  BRAM_ADDR,
        input  BRAM_WRDATA,
        input  BRAM_WE,
        input  BRAM_EN,
        input  BRAM_RST,
        input  done,
        output BRAM_RDDATA
    );
endinterface

// File: rtl/bram_resp_mem.sv
// bram_resp_mem
//   Synthesizable memory end of the PE controller BRAM port. Port A serves
//   the controller (1-cycle read-first reads, byte-lane writes). When the
//   controller raises done, an internal port B walks the whole array and
//   publishes the 32-bit wrap-around sum of all words.
//
//   Ports:
//     aclk          single clock (the master's BRAM_CLK must come from it)
//     aresetn       asynchronous active-low reset (array is not cleared)
//     bus           bram_resp_mem_if.slave: BRAM_ADDR/WRDATA/WE/EN/RST/RDDATA, done
//     scan_busy     checksum scan in progress
//     scan_valid    scan_sum holds a finished checksum
//     scan_sum      sum of all words, modulo 2^32
//     wr_count      number of write cycles, saturating at 16'hFFFF
//     misalign_err  sticky non-word-aligned access flag
//
//   Build option: define BRAM_ALIGN_CHECK_EN to build the alignment checker;
//   otherwise misalign_err is tied low.
//
//   Checksum FSM
//   state | meaning
//   IDLE  | waiting for a rising edge on done
//   SCAN  | port B reading words 0..DEPTH-1, accumulating one cycle behind
//   HOLD  | scan_sum valid, waiting for done to drop
module bram_resp_mem #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter bit INIT_ZERO       = 1'b1
) (
    input  logic            aclk,
    input  logic            aresetn,
    bram_resp_mem_if.slave  bus,
    output logic            scan_busy,
    output logic            scan_valid,
    output logic [31:0]     scan_sum,
    output logic [15:0]     wr_count,
    output logic            misalign_err
);
    localparam int          AW        = BRAM_ADDR_WIDTH - 2;
    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] SCAN_LAST = (AW + 1)'(DEPTH);
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Configuration-time contents; reset never touches the array.
    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [AW-1:0] idx;
    logic          wr_en;
    logic [31:0]   rdata_q;
    logic [15:0]   wr_cnt_q;
    logic          done_q;
    logic          done_rise;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   sum_q, sum_d;
    logic [31:0]   rdb_q;
    logic          scan_rd_en;
    logic [AW-1:0] scan_idx;

    assign idx   = bus.BRAM_ADDR[BRAM_ADDR_WIDTH-1:2];
    assign wr_en = bus.BRAM_EN && (bus.BRAM_WE != 4'h0);

    // Array writes and the port B read share one block; both reads sample
    // the pre-write word, which gives read-first on either port.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.BRAM_WE[i]) begin
                    mem[idx][8*i +: 8] <= bus.BRAM_WRDATA[8*i +: 8];
                end
            end
        end
        if (scan_rd_en) begin
            rdb_q <= mem[scan_idx];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= '0;
        end else if (bus.BRAM_EN) begin
            rdata_q <= bus.BRAM_RST ? 32'h0 : mem[idx];
        end
    end

    assign bus.BRAM_RDDATA = rdata_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_q <= '0;
        end else if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign wr_count = wr_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= bus.done;
        end
    end

    assign done_rise = bus.done & ~done_q;

    // cnt_q doubles as the port B read pointer (low AW bits) and the scan
    // phase: reads are issued for 0..DEPTH-1, and at DEPTH the final word
    // is in rdb_q and gets folded straight into scan_sum.
    assign scan_rd_en = (state_q == ST_SCAN) && !cnt_q[AW];
    assign scan_idx   = cnt_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (done_rise) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SCAN_LAST) begin
                    sum_d   = acc_q + rdb_q;
                    state_d = ST_HOLD;
                end else if (cnt_q != '0) begin
                    acc_d = acc_q + rdb_q;
                end
            end
            ST_HOLD: begin
                if (!bus.done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign scan_busy  = (state_q == ST_SCAN);
    assign scan_valid = (state_q == ST_HOLD);
    assign scan_sum   = sum_q;

`ifdef BRAM_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mis_q <= 1'b0;
        end else if (bus.BRAM_EN && (bus.BRAM_ADDR[1:0] != 2'b00)) begin
            mis_q <= 1'b1;
        end
    end

    assign misalign_err = mis_q;
`else
    logic [1:0] addr_lsb_unused;

    assign addr_lsb_unused = bus.BRAM_ADDR[1:0];
    assign misalign_err    = 1'b0;
`endif
endmodule

// File: doc/bram_resp_mem.md
Name: bram_resp_mem

Overview:
- Synthesizable BRAM-port responder: the memory end of the BRAM master interface driven by our PE controllers (BRAM_ADDR/WRDATA/WE/RDDATA, plus the done handshake).
- Replaces the behavioural memory model so controller + memory can run on fabric.
- After the controller asserts done, it runs a checksum scan over the whole array, so results can be checked without a file dump.

Parameters:
- BRAM_ADDR_WIDTH, 15, byte-address width. Word depth DEPTH = 2^(BRAM_ADDR_WIDTH-2).
- INIT_ZERO, 1: 1 = array initialised to zero at configuration; 0 = contents left undefined.

Ports:
- aclk  in  1  single clock. The master's BRAM_CLK output must be sourced from aclk; it is not a port here.
- aresetn  in  1  reset, asynchronous, active-low.
- BRAM_ADDR  in  BRAM_ADDR_WIDTH  byte address. Word index = BRAM_ADDR[BRAM_ADDR_WIDTH-1:2].
- BRAM_WRDATA  in  32  write data.
- BRAM_WE  in  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- BRAM_EN  in  1  port enable.
- BRAM_RST  in  1  synchronous clear of the read-data register.
- BRAM_RDDATA  out  32  registered read data.
- done  in  1  controller completion flag.
- scan_busy  out  1  checksum scan in progress.
- scan_valid  out  1  scan_sum is valid.
- scan_sum  out  32  sum of all words, modulo 2^32.
- wr_count  out  16  number of write cycles, saturating.
- misalign_err  out  1  sticky alignment error (see Optional Feature).

Behaviour:
- Async reset (aresetn=0):
  - BRAM_RDDATA=0, scan_busy=0, scan_valid=0, scan_sum=0, wr_count=0, misalign_err=0.
  - FSM goes to IDLE and the done-edge register is cleared.
  - Array contents are not reset.
- Port A (master side):
  - On each aclk rising edge with BRAM_EN=1, BRAM_RDDATA <= mem[idx]. Read latency is 1 cycle.
  - Read-first: when a read and a write hit the same address in one cycle, BRAM_RDDATA returns the old word.
  - A write occurs when BRAM_EN=1 and BRAM_WE!=0; only the enabled byte lanes are updated.
  - BRAM_EN=0: no read, no write, BRAM_RDDATA holds its value.
  - BRAM_RST=1 with BRAM_EN=1: BRAM_RDDATA <= 0 that cycle. Any write still occurs.
- wr_count: increments on every write cycle and saturates at 16'hFFFF. Only aresetn clears it.
- Done edge: done_rise = done & ~done_q, where done_q is done registered on aclk.
- Checksum FSM:
  - IDLE: on done_rise -> SCAN. Clear acc and ptr, scan_busy=1, scan_valid=0.
  - SCAN: port B reads mem[ptr] and ptr increments every cycle from 0 to DEPTH-1. Port B data arrives 1 cycle later and is added into acc (32-bit, wrap). When the last word has been accumulated (DEPTH+1 cycles after entering SCAN): scan_sum <= acc + last word, go to HOLD.
  - HOLD: scan_busy=0, scan_valid=1, scan_sum stable. When done=0 -> IDLE with scan_valid=0 on the next cycle; scan_sum keeps its value.
  - done_rise in SCAN or HOLD is ignored.
  - Reset during SCAN aborts the scan: FSM to IDLE, outputs at reset values.
- Port A stays fully operational during SCAN. A same-cycle write to the word port B is reading gives port B the old word.
- Arithmetic: unsigned, modulo 2^32. No overflow flag.

Optional Feature:
- Macro: BRAM_ALIGN_CHECK_EN.
- Defined: misalign_err is set when BRAM_EN=1 and BRAM_ADDR[1:0]!=0, and stays set until aresetn. The access still completes using the word index.
- Undefined: misalign_err is tied to 0 and no check logic is built.

Test Plan:
- Reset then read: aresetn low for 100 cycles, then read addr 0x0 -> BRAM_RDDATA=0 the cycle after EN. All status outputs 0 and wr_count=0 throughout.
- Byte-lane write: write 0x11223344 to 0x10 with WE=4'hF, then 0xAABBCCDD to 0x10 with WE=4'b0101, then read 0x10 -> 0x11BB33DD, 1-cycle latency. wr_count=2.
- Read-first collision: mem[0x20]=0x5. Same cycle: write 0x9 to 0x20 and read 0x20 -> RDDATA=0x5. Next read returns 0x9.
- BRAM_RST: RDDATA=0x9, pulse BRAM_RST with EN=1 -> RDDATA=0 next cycle. mem[0x20] unchanged (still 0x9).
- Checksum: write words 1..64 to addr 0x0..0xFC (all other words 0), then raise done -> scan_busy high for exactly DEPTH+1 cycles, then scan_valid=1 with scan_sum=2080. Drop done -> scan_valid=0 next cycle.
- Wrap and abort:
  - Two words 0xFFFFFFFF and 0x2, done -> scan_sum=0x1.
  - Repeat and assert aresetn mid-SCAN -> scan_busy=0, scan_valid=0 immediately.
  - With BRAM_ALIGN_CHECK_EN defined, a read at 0x3 -> misalign_err=1 and it stays 1 until reset.
